// File: rtl/verif_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : verif_scheduler
//  Description : Sweeps two search windows across the active line (A moves
//                right, B moves left) once per frame, grants detection hits
//                from two engines round-robin, and holds a granted bounding
//                box for HOLD_FRAMES frames before rescanning.
//  Ports       : Clk, Rst (async active-low)        - clock / reset
//                enable                             - search enable
//                H_Cont, V_Cont                     - pixel / line counters
//                hit_a/box_a, hit_b/box_b           - engine detections
//                win_a_x1/x2, win_b_x1/x2           - engine search windows
//                search_en                          - engines armed
//                x1, y1, x2, y2, ativo              - granted box and valid
//                state                              - FSM state code
//  Options     : SCHED_BOX_CHECK_EN - reject malformed / off-frame boxes
//  Revision    : 1.0 - initial release
// ============================================================================
module verif_scheduler #(
   parameter int FRAME_W     = 800,
   parameter int WIN_W       = 250,
   parameter int STEP        = 10,
   parameter int HOLD_FRAMES = 30
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic        enable,
   input  logic [12:0] H_Cont,
   input  logic [12:0] V_Cont,
   input  logic        hit_a,
   input  logic [51:0] box_a,
   input  logic        hit_b,
   input  logic [51:0] box_b,
   output logic [12:0] win_a_x1,
   output logic [12:0] win_a_x2,
   output logic [12:0] win_b_x1,
   output logic [12:0] win_b_x2,
   output logic        search_en,
   output logic [12:0] x1,
   output logic [12:0] y1,
   output logic [12:0] x2,
   output logic [12:0] y2,
   output logic        ativo,
   output logic [1:0]  state
);

   localparam logic [1:0]  c_IDLE   = 2'd0;
   localparam logic [1:0]  c_SEARCH = 2'd1;
   localparam logic [1:0]  c_LOCKED = 2'd2;

   localparam int          c_CNT_W  = $clog2(HOLD_FRAMES + 1);
   localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_FRAMES - 1);

   localparam logic [12:0] c_WA_X1  = 13'd0;
   localparam logic [12:0] c_WA_X2  = 13'(WIN_W);
   localparam logic [12:0] c_WB_X1  = 13'(FRAME_W);
   localparam logic [12:0] c_WB_X2  = 13'(FRAME_W - WIN_W);
   localparam logic [12:0] c_STEP   = 13'(STEP);

   logic [1:0]         state_q, state_d;
   logic [12:0]        wa1_q, wa1_d, wa2_q, wa2_d, wb1_q, wb1_d, wb2_q, wb2_d;
   logic [51:0]        box_q, box_d;
   logic               ativo_q, ativo_d;
   logic [c_CNT_W-1:0] hold_q, hold_d;
   logic               last_b_q, last_b_d;   // 1: engine B was granted last
   logic               fs_q;

   logic               w_origin, w_fs;
   logic               w_valid_a, w_valid_b, w_grant_a, w_grant_b;
   logic [12:0]        w_na1, w_na2, w_nb1, w_nb2;

   // Frame start: rising edge of the (0,0) pixel position.
   assign w_origin = (H_Cont == 13'd0) && (V_Cont == 13'd0);
   assign w_fs     = w_origin && !fs_q;

`ifdef SCHED_BOX_CHECK_EN
   function automatic logic box_ok(input logic [51:0] b);
      return (b[25:13] > b[51:39]) && (b[12:0] > b[38:26]) &&
             (b[25:13] <= c_WB_X1);
   endfunction
   assign w_valid_a = hit_a && box_ok(box_a);
   assign w_valid_b = hit_b && box_ok(box_b);
`else
   assign w_valid_a = hit_a;
   assign w_valid_b = hit_b;
`endif

   // On a tie the engine that was not granted last wins.
   assign w_grant_a = w_valid_a && (!w_valid_b ||  last_b_q);
   assign w_grant_b = w_valid_b && (!w_valid_a || !last_b_q);

   assign w_na1 = wa1_q + c_STEP;
   assign w_na2 = wa2_q + c_STEP;
   assign w_nb1 = wb1_q - c_STEP;
   assign w_nb2 = wb2_q - c_STEP;

   always_comb begin
      state_d  = state_q;
      wa1_d    = wa1_q;
      wa2_d    = wa2_q;
      wb1_d    = wb1_q;
      wb2_d    = wb2_q;
      box_d    = box_q;
      ativo_d  = ativo_q;
      hold_d   = hold_q;
      last_b_d = last_b_q;

      if (!enable) begin
         state_d = c_IDLE;
         ativo_d = 1'b0;
         hold_d  = '0;
         wa1_d   = c_WA_X1;
         wa2_d   = c_WA_X2;
         wb1_d   = c_WB_X1;
         wb2_d   = c_WB_X2;
      end else begin
         case (state_q)
            c_IDLE: begin
               wa1_d = c_WA_X1;
               wa2_d = c_WA_X2;
               wb1_d = c_WB_X1;
               wb2_d = c_WB_X2;
               if (w_fs) state_d = c_SEARCH;
            end
            c_SEARCH: begin
               // A grant takes priority over a coincident frame step.
               if (w_grant_a || w_grant_b) begin
                  box_d    = w_grant_a ? box_a : box_b;
                  ativo_d  = 1'b1;
                  last_b_d = w_grant_b;
                  state_d  = c_LOCKED;
               end else if (w_fs) begin
                  if (w_na1 >= w_nb2) begin
                     // Windows crossed: sweep done without a detection.
                     wa1_d   = c_WA_X1;
                     wa2_d   = c_WA_X2;
                     wb1_d   = c_WB_X1;
                     wb2_d   = c_WB_X2;
                     ativo_d = 1'b0;
                  end else begin
                     wa1_d = w_na1;
                     wa2_d = w_na2;
                     wb1_d = w_nb1;
                     wb2_d = w_nb2;
                  end
               end
            end
            c_LOCKED: begin
               if (w_fs) begin
                  if (hold_q == c_HOLD_LAST) begin
                     hold_d  = '0;
                     wa1_d   = c_WA_X1;
                     wa2_d   = c_WA_X2;
                     wb1_d   = c_WB_X1;
                     wb2_d   = c_WB_X2;
                     state_d = c_SEARCH;
                  end else begin
                     hold_d = hold_q + 1'b1;
                  end
               end
            end
            default: state_d = c_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state_q  <= c_IDLE;
         wa1_q    <= c_WA_X1;
         wa2_q    <= c_WA_X2;
         wb1_q    <= c_WB_X1;
         wb2_q    <= c_WB_X2;
         box_q    <= '0;
         ativo_q  <= 1'b0;
         hold_q   <= '0;
         last_b_q <= 1'b1;
         fs_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         wa1_q    <= wa1_d;
         wa2_q    <= wa2_d;
         wb1_q    <= wb1_d;
         wb2_q    <= wb2_d;
         box_q    <= box_d;
         ativo_q  <= ativo_d;
         hold_q   <= hold_d;
         last_b_q <= last_b_d;
         fs_q     <= w_origin;
      end
   end

   assign win_a_x1  = wa1_q;
   assign win_a_x2  = wa2_q;
   assign win_b_x1  = wb1_q;
   assign win_b_x2  = wb2_q;
   assign search_en = (state_q == c_SEARCH);
   assign x1        = box_q[51:39];
   assign y1        = box_q[38:26];
   assign x2        = box_q[25:13];
   assign y2        = box_q[12:0];
   assign ativo     = ativo_q;
   assign state     = state_q;

endmodule
`default_nettype wire

// File: tb/tb_verif_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_verif_scheduler
//  Description : Directed self-checking bench for verif_scheduler.
//  Ports       : none (top-level bench)
//  Options     : SCHED_BOX_CHECK_EN - selects expectations for box checking
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_verif_scheduler;

   logic        Clk = 1'b0;
   logic        Rst = 1'b0;
   logic        enable = 1'b0;
   logic [12:0] H_Cont = 13'd1;
   logic [12:0] V_Cont = 13'd0;
   logic        hit_a = 1'b0;
   logic [51:0] box_a = '0;
   logic        hit_b = 1'b0;
   logic [51:0] box_b = '0;
   logic [12:0] win_a_x1, win_a_x2, win_b_x1, win_b_x2;
   logic        search_en;
   logic [12:0] x1, y1, x2, y2;
   logic        ativo;
   logic [1:0]  state;

   int n_tests = 0;
   int n_fail  = 0;

   verif_scheduler dut (
      .Clk(Clk), .Rst(Rst), .enable(enable), .H_Cont(H_Cont), .V_Cont(V_Cont),
      .hit_a(hit_a), .box_a(box_a), .hit_b(hit_b), .box_b(box_b),
      .win_a_x1(win_a_x1), .win_a_x2(win_a_x2),
      .win_b_x1(win_b_x1), .win_b_x2(win_b_x2),
      .search_en(search_en), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .ativo(ativo), .state(state)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic logic [51:0] mk_box(input int a, input int b, input int c, input int d);
      return {13'(a), 13'(b), 13'(c), 13'(d)};
   endfunction

   // One frame start: counters sit at (0,0) for exactly one clock.
   task automatic do_fs();
      @(negedge Clk); H_Cont = 13'd0; V_Cont = 13'd0;
      @(negedge Clk); H_Cont = 13'd1;
   endtask

   task automatic check_win(input string tag, input int a1, input int a2, input int b1, input int b2);
      check({tag, ".wa1"}, 64'(win_a_x1), 64'(a1));
      check({tag, ".wa2"}, 64'(win_a_x2), 64'(a2));
      check({tag, ".wb1"}, 64'(win_b_x1), 64'(b1));
      check({tag, ".wb2"}, 64'(win_b_x2), 64'(b2));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      #12;
      check("rst.state", 64'(state), 64'd0);
      check("rst.sen", 64'(search_en), 64'd0);
      check("rst.ativo", 64'(ativo), 64'd0);
      check("rst.x1", 64'(x1), 64'd0);
      check_win("rst", 0, 250, 800, 550);

      @(negedge Clk); Rst = 1'b1; enable = 1'b1;
      do_fs();
      check("fs1.state", 64'(state), 64'd1);
      check("fs1.sen", 64'(search_en), 64'd1);
      check_win("fs1", 0, 250, 800, 550);

      // Sweep
      repeat (27) do_fs();
      check_win("sw27", 270, 520, 530, 280);
      do_fs();
      check_win("sw28", 0, 250, 800, 550);
      check("sw28.state", 64'(state), 64'd1);

      // First tie: A wins
      @(negedge Clk);
      hit_a = 1'b1; box_a = mk_box(100, 50, 200, 150);
      hit_b = 1'b1; box_b = mk_box(300, 60, 400, 160);
      @(negedge Clk); hit_a = 1'b0; hit_b = 1'b0;
      check("tie1.state", 64'(state), 64'd2);
      check("tie1.ativo", 64'(ativo), 64'd1);
      check("tie1.sen", 64'(search_en), 64'd0);
      check("tie1.x1", 64'(x1), 64'd100);
      check("tie1.y1", 64'(y1), 64'd50);
      check("tie1.x2", 64'(x2), 64'd200);
      check("tie1.y2", 64'(y2), 64'd150);

      // Hits ignored while locked
      @(negedge Clk); hit_a = 1'b1; box_a = mk_box(5, 6, 7, 8);
      @(negedge Clk); hit_a = 1'b0;
      check("lk.ign.x1", 64'(x1), 64'd100);
      check("lk.ign.state", 64'(state), 64'd2);

      // Hold for 30 frames
      repeat (29) do_fs();
      check("hold29.state", 64'(state), 64'd2);
      do_fs();
      check("hold30.state", 64'(state), 64'd1);
      check("hold30.ativo", 64'(ativo), 64'd1);
      check("hold30.x1", 64'(x1), 64'd100);

      // Second tie: B wins
      @(negedge Clk);
      hit_a = 1'b1; box_a = mk_box(100, 50, 200, 150);
      hit_b = 1'b1; box_b = mk_box(300, 60, 400, 160);
      @(negedge Clk); hit_a = 1'b0; hit_b = 1'b0;
      check("tie2.state", 64'(state), 64'd2);
      check("tie2.x1", 64'(x1), 64'd300);
      check("tie2.y2", 64'(y2), 64'd160);
      repeat (30) do_fs();
      check("hold2.state", 64'(state), 64'd1);

      // Full sweep without hit clears ativo, box kept
      repeat (27) do_fs();
      check("clr27.ativo", 64'(ativo), 64'd1);
      do_fs();
      check("clr28.ativo", 64'(ativo), 64'd0);
      check("clr28.x1", 64'(x1), 64'd300);
      check_win("clr28", 0, 250, 800, 550);

      // Hit coincident with frame start: grant, no window step
      do_fs();
      check_win("step1", 10, 260, 790, 540);
      @(negedge Clk);
      H_Cont = 13'd0; V_Cont = 13'd0;
      hit_b = 1'b1; box_b = mk_box(20, 30, 40, 50);
      @(negedge Clk); H_Cont = 13'd1; hit_b = 1'b0;
      check("hitfs.state", 64'(state), 64'd2);
      check("hitfs.x1", 64'(x1), 64'd20);
      check_win("hitfs", 10, 260, 790, 540);

      // Disable during LOCKED
      @(negedge Clk); enable = 1'b0;
      @(negedge Clk);
      check("dis.state", 64'(state), 64'd0);
      check("dis.ativo", 64'(ativo), 64'd0);
      check("dis.sen", 64'(search_en), 64'd0);
      check_win("dis", 0, 250, 800, 550);

      // Malformed box (x2 < x1)
      enable = 1'b1;
      do_fs();
      check("reen.state", 64'(state), 64'd1);
      @(negedge Clk); hit_a = 1'b1; box_a = mk_box(100, 10, 90, 20);
      @(negedge Clk); hit_a = 1'b0;
`ifdef SCHED_BOX_CHECK_EN
      check("badbox.state", 64'(state), 64'd1);
      check("badbox.ativo", 64'(ativo), 64'd0);
`else
      check("badbox.state", 64'(state), 64'd2);
      check("badbox.x1", 64'(x1), 64'd100);
`endif

      // Asynchronous reset discards everything
      do_fs();
      @(negedge Clk); #2 Rst = 1'b0;
      #1;
      check("arst.state", 64'(state), 64'd0);
      check("arst.ativo", 64'(ativo), 64'd0);
      check("arst.x1", 64'(x1), 64'd0);
      check("arst.y2", 64'(y2), 64'd0);
      check_win("arst", 0, 250, 800, 550);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
